fp_mult_seq: RTL

Sequential floating-point multiplier that consumes two operands already decoded by the operand-analyzer stage (sign, 8-bit exponent, mantissa with explicit hidden bit, NaN/Inf/Zero flags) and produces a packed DATA_W-bit product. Mantissas are multiplied by an iterative radix-2 shift-add datapath, then normalized and packed. Special operands bypass the datapath. Valid/ready handshakes sit on both sides.

---
 rtl/fp_mult_seq.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_mult_seq.sv
// fp_mult_seq: sequential floating-point multiplier for pre-decoded operands.
// The mantissas are multiplied by a radix-2 shift-add loop, then normalized,
// truncated and packed. Special operand classes bypass the datapath.
// Only one operation is in flight at a time, with valid/ready on both sides.
module fp_mult_seq #(
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                a_sign,
    input  logic                b_sign,
    input  logic [7:0]          a_exp,
    input  logic [7:0]          b_exp,
    input  logic [DATA_W-9:0]   a_mant,
    input  logic [DATA_W-9:0]   b_mant,
    input  logic                a_nan,
    input  logic                a_inf,
    input  logic                a_zero,
    input  logic                b_nan,
    input  logic                b_inf,
    input  logic                b_zero,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   result,
    output logic                out_nan,
    output logic                out_inf,
    output logic                out_zero
);

    // Mantissa width (hidden bit included), fraction width, counter width.
    localparam int M     = DATA_W - 8;
    localparam int F     = DATA_W - 9;
    localparam int CNT_W = $clog2(M + 1);

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
    localparam logic [DATA_W-1:0] QNAN = {1'b0, 8'hFF, 1'b1, {(F-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    // Denormals share the exponent of the smallest normal.
    function automatic logic signed [10:0] f_eff_exp(input logic [7:0] e);
        if (e == 8'd0)
            return 11'sd1;
        else
            return $signed({3'b000, e});
    endfunction

    // Range check and pack. Returns {word, inf flag, zero flag}.
    // Overflow saturates to infinity, underflow flushes to signed zero,
    // and the fraction arrives already truncated (round toward zero).
    function automatic logic [DATA_W+1:0] f_pack(
        input logic               s,
        input logic signed [10:0] e,
        input logic [F-1:0]       frac
    );
        if (e >= 11'sd255)
            return {s, 8'hFF, {F{1'b0}}, 2'b10};
        else if (e <= 11'sd0)
            return {s, 8'h00, {F{1'b0}}, 2'b01};
        else
            return {s, e[7:0], frac, 2'b00};
    endfunction

    state_t                 r_state;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [DATA_W-1:0]      r_result;
    logic                   r_nan;
    logic                   r_inf;
    logic                   r_zero;
    logic                   r_sign;
    logic signed [10:0]     r_e;
    logic [CNT_W-1:0]       r_cnt;
    logic [2*M-1:0]         r_p;
    logic [2*M-1:0]         r_mcand;
    logic [M-1:0]           r_mplier;

    logic                   w_sign;
    logic                   w_spec_nan;
    logic                   w_spec_inf;
    logic                   w_spec_zero;
    logic signed [10:0]     w_e_init;
    logic [2*M-1:0]         w_p_acc;
    logic [2*M-1:0]         w_p_shr;
    logic [2*M-1:0]         w_p_shl;
    logic signed [10:0]     w_e_inc;
    logic signed [10:0]     w_e_dec;
    logic [F-1:0]           w_frac;
    logic [F-1:0]           w_frac_hi;
    logic [DATA_W+1:0]      w_pack;
    logic [DATA_W+1:0]      w_pack_hi;

    // Accept-time classification and exponent sum.
    assign w_sign      = a_sign ^ b_sign;
    assign w_spec_nan  = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
    assign w_spec_inf  = a_inf | b_inf;
    assign w_spec_zero = a_zero | b_zero;
    assign w_e_init    = f_eff_exp(a_exp) + f_eff_exp(b_exp) - 11'sd127;

    // Shift-add step: add the aligned multiplicand when the multiplier LSB is set.
    assign w_p_acc = r_mplier[0] ? (r_p + r_mcand) : r_p;

    // Normalization candidates.
    assign w_p_shr = r_p >> 1;
    assign w_p_shl = r_p << 1;
    assign w_e_inc = r_e + 11'sd1;
    assign w_e_dec = r_e - 11'sd1;

    // Fraction field sits just below the hidden bit at P[2M-2].
    assign w_frac    = r_p[2*M-3:M-1];
    assign w_frac_hi = w_p_shr[2*M-3:M-1];
    assign w_pack    = f_pack(r_sign, r_e, w_frac);
    assign w_pack_hi = f_pack(r_sign, w_e_inc, w_frac_hi);

    // Control FSM and datapath registers; all outputs come straight from registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_nan       <= 1'b0;
            r_inf       <= 1'b0;
            r_zero      <= 1'b0;
            r_sign      <= 1'b0;
            r_e         <= '0;
            r_cnt       <= '0;
            r_p         <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
        end else begin
            case (r_state)
                // Accept: special classes go straight to DONE, others start the loop.
                IDLE: begin
                    if (in_valid) begin
                        r_sign     <= w_sign;
                        r_in_ready <= 1'b0;
                        if (w_spec_nan) begin
                            r_result    <= QNAN;
                            r_nan       <= 1'b1;
                            r_inf       <= 1'b0;
                            r_zero      <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else if (w_spec_inf) begin
                            r_result    <= {w_sign, 8'hFF, {F{1'b0}}};
                            r_nan       <= 1'b0;
                            r_inf       <= 1'b1;
                            r_zero      <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else if (w_spec_zero) begin
                            r_result    <= {w_sign, 8'h00, {F{1'b0}}};
                            r_nan       <= 1'b0;
                            r_inf       <= 1'b0;
                            r_zero      <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_e      <= w_e_init;
                            r_p      <= '0;
                            r_mcand  <= {{M{1'b0}}, a_mant};
                            r_mplier <= b_mant;
                            r_cnt    <= CNT_W'(M);
                            r_state  <= MUL;
                        end
                    end
                end

                // ---- MUL: one multiplier bit per cycle, exactly M cycles ----
                MUL: begin
                    r_p      <= w_p_acc;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1))
                        r_state <= NORM;
                end

                // ---- NORM: bring the leading one to P[2M-2], then pack ----
                NORM: begin
                    if (r_p[2*M-1]) begin
                        r_p         <= w_p_shr;
                        r_e         <= w_e_inc;
                        r_result    <= w_pack_hi[DATA_W+1:2];
                        r_inf       <= w_pack_hi[1];
                        r_zero      <= w_pack_hi[0];
                        r_nan       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (r_p[2*M-2]) begin
                        r_result    <= w_pack[DATA_W+1:2];
                        r_inf       <= w_pack[1];
                        r_zero      <= w_pack[0];
                        r_nan       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (r_p == '0) begin
                        // Zero mantissas without a zero flag would never normalize;
                        // flush them to signed zero instead of spinning forever.
                        r_result    <= {r_sign, 8'h00, {F{1'b0}}};
                        r_inf       <= 1'b0;
                        r_zero      <= 1'b1;
                        r_nan       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_p <= w_p_shl;
                        r_e <= w_e_dec;
                    end
                end

                // ---- DONE: hold the result until the consumer takes it ----
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign out_nan   = r_nan;
    assign out_inf   = r_inf;
    assign out_zero  = r_zero;

endmodule
